// File: rtl/uns_acc_ctrl_if.sv
// Command/result and accumulator-side signal bundle for the accumulator sequencer.
// The master side is the command issuer plus accumulator; the slave side is the sequencer.
interface uns_acc_ctrl_if #(
  parameter int unsigned CNT_W = 6
);
  localparam int unsigned DATA_W = 6;
  localparam int unsigned STEP_W = 3;
  localparam int unsigned SEL_W  = 2;

  logic              i_start;
  logic [DATA_W-1:0] i_target;
  logic [STEP_W-1:0] i_step1;
  logic [STEP_W-1:0] i_step2;
  logic [SEL_W-1:0]  i_mode;
  logic [DATA_W-1:0] i_acc_data;
  logic              i_acc_carry;

  logic [STEP_W-1:0] o_data1;
  logic [STEP_W-1:0] o_data2;
  logic [SEL_W-1:0]  o_sel;
  logic              o_acc_rst_n;
  logic              o_busy;
  logic              o_done;
  logic [1:0]        o_status;
  logic [DATA_W-1:0] o_result;
  logic [CNT_W-1:0]  o_cycles;

  modport master (
    output i_start, i_target, i_step1, i_step2, i_mode, i_acc_data, i_acc_carry,
    input  o_data1, o_data2, o_sel, o_acc_rst_n, o_busy, o_done, o_status, o_result, o_cycles
  );

  modport slave (
    input  i_start, i_target, i_step1, i_step2, i_mode, i_acc_data, i_acc_carry,
    output o_data1, o_data2, o_sel, o_acc_rst_n, o_busy, o_done, o_status, o_result, o_cycles
  );
endinterface

// File: rtl/uns_acc_ctrl.sv
// Sequencer for the unsigned 6-bit accumulator: clears it, streams additions until
// target/carry/budget, then reports result, addition count and status.
module uns_acc_ctrl #(
  parameter int unsigned MAX_CYCLES = 63,
  parameter int unsigned CNT_W      = 6
) (
  input  logic            clk,
  input  logic            i_rst_n,
  uns_acc_ctrl_if.slave   bus
);
  localparam int unsigned DATA_W = 6;
  localparam int unsigned STEP_W = 3;
  localparam int unsigned SEL_W  = 2;

  localparam logic [SEL_W-1:0] SEL_HOLD = 2'b11;
  localparam logic [SEL_W-1:0] MODE_BAD = 2'b11;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_OVF     = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_BADMODE = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_FIN
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] target_q, target_d;
  logic [STEP_W-1:0] step1_q, step1_d;
  logic [STEP_W-1:0] step2_q, step2_d;
  logic [SEL_W-1:0]  mode_q, mode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        status_q, status_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;
  logic              acc_rst_n_q, acc_rst_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [SEL_W-1:0]  sel_c;
  logic              term_c;

  // Next-state, datapath capture and the combinational select toward the accumulator
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    step1_d  = step1_q;
    step2_d  = step2_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    result_d = result_q;
    cycles_d = cycles_q;
    sel_c    = SEL_HOLD;
    term_c   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          target_d = bus.i_target;
          step1_d  = bus.i_step1;
          step2_d  = bus.i_step2;
          mode_d   = bus.i_mode;
          cnt_d    = '0;
          result_d = '0;
          cycles_d = '0;
          if (bus.i_mode == MODE_BAD) begin
            status_d = ST_BADMODE;
            state_d  = S_FIN;
          end else begin
            status_d = ST_OK;
            state_d  = S_CLEAR;
          end
        end
      end
      S_CLEAR: state_d = S_RUN;
      S_RUN: begin
        // Carry beats target hit, which beats the addition budget
        if (bus.i_acc_carry) begin
          status_d = ST_OVF;
          term_c   = 1'b1;
        end else if (bus.i_acc_data >= target_q) begin
          status_d = ST_OK;
          term_c   = 1'b1;
        end else if (cnt_q == CNT_W'(MAX_CYCLES)) begin
          status_d = ST_TIMEOUT;
          term_c   = 1'b1;
        end else begin
          sel_c = mode_q;
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (term_c) begin
          result_d = bus.i_acc_data;
          cycles_d = cnt_q;
          state_d  = S_FIN;
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    acc_rst_n_d = (state_d != S_CLEAR);
    busy_d      = (state_d == S_CLEAR) || (state_d == S_RUN);
    done_d      = (state_d == S_FIN);
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      target_q    <= '0;
      step1_q     <= '0;
      step2_q     <= '0;
      mode_q      <= SEL_HOLD;
      cnt_q       <= '0;
      status_q    <= ST_OK;
      result_q    <= '0;
      cycles_q    <= '0;
      acc_rst_n_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      step1_q     <= step1_d;
      step2_q     <= step2_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      status_q    <= status_d;
      result_q    <= result_d;
      cycles_q    <= cycles_d;
      acc_rst_n_q <= acc_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.o_data1     = step1_q;
  assign bus.o_data2     = step2_q;
  assign bus.o_sel       = sel_c;
  assign bus.o_acc_rst_n = acc_rst_n_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;
  assign bus.o_status    = status_q;
  assign bus.o_result    = result_q;
  assign bus.o_cycles    = cycles_q;

endmodule
